// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle mult/div unit beside X: latch op, pulse start, stall while it iterates,
// then present a one-cycle writeback for XM. A watchdog ends the op if the unit never reports ready.
module multdiv_sequencer #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int MAX_CYCLES = 40
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              x_is_mult_i,
    input  logic              x_is_div_i,
    input  logic [DATA_W-1:0] x_operand_a_i,
    input  logic [DATA_W-1:0] x_operand_b_i,
    input  logic [REG_W-1:0]  x_rd_i,
    output logic              md_ctrl_mult_o,
    output logic              md_ctrl_div_o,
    output logic [DATA_W-1:0] md_operand_a_o,
    output logic [DATA_W-1:0] md_operand_b_o,
    input  logic [DATA_W-1:0] md_result_i,
    input  logic              md_exception_i,
    input  logic              md_result_rdy_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [REG_W-1:0]  wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_exception_o,
    output logic              timeout_o
);

    localparam int                CNT_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [REG_W-1:0]    rd_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;
    logic                ctrl_mult_q;
    logic                ctrl_div_q;
    logic                wb_valid_q;
    logic [REG_W-1:0]    wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                wb_exc_q;
    logic                timeout_q;

    logic                req;
    logic                rd_nonzero;

    assign req        = x_is_mult_i | x_is_div_i;
    assign rd_nonzero = (rd_q != '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_exc_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // Start pulse and writeback fields live for exactly one cycle.
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_exc_q    <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        opa_q       <= x_operand_a_i;
                        opb_q       <= x_operand_b_i;
                        rd_q        <= x_rd_i;
                        ctrl_mult_q <= x_is_mult_i;
                        ctrl_div_q  <= ~x_is_mult_i;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    // Any rdy seen here belongs to a previous op and is ignored.
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (md_result_rdy_i) begin
                        wb_valid_q <= rd_nonzero;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= md_exception_i ? '0 : md_result_i;
                        wb_exc_q   <= md_exception_i;
                        state_q    <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        wb_valid_q <= rd_nonzero;
                        wb_rd_q    <= rd_q;
                        wb_exc_q   <= 1'b1;
                        timeout_q  <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // The finishing instruction is still in X; its request must not restart us.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o = ((state_q == S_IDLE) & req) | (state_q == S_START) | (state_q == S_WAIT);

    assign md_ctrl_mult_o = ctrl_mult_q;
    assign md_ctrl_div_o  = ctrl_div_q;
    assign md_operand_a_o = opa_q;
    assign md_operand_b_o = opb_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_exception_o = wb_exc_q;
    assign timeout_o      = timeout_q;

endmodule
